// File: rtl/button_pio_debounce_if.sv
// Avalon-MM slave bus bundle for button_pio_debounce: word address, strobes, write and read data.
interface button_pio_debounce_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/button_pio_debounce.sv
// WIDTH-channel button PIO: 2-FF synchroniser, per-channel debounce, rise/fall edge capture, masked IRQ.
// Optional macro BUTTON_PIO_EVENT_COUNT_EN adds a saturating edge-event counter at address 7.
module button_pio_debounce #(
  parameter int WIDTH      = 4,
  parameter int DB_CNT_W   = 16,
  parameter int DB_DEFAULT = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  button_pio_debounce_if.slave bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_RAW    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_RISE   = 3'd4;
  localparam logic [2:0] ADDR_FALL   = 3'd5;
  localparam logic [2:0] ADDR_PERIOD = 3'd6;
  localparam logic [2:0] ADDR_EVENT  = 3'd7;

  function automatic logic [DB_CNT_W-1:0] cnt_sat_inc(input logic [DB_CNT_W-1:0] v);
    return (&v) ? v : v + DB_CNT_W'(1);
  endfunction

  // Compare in one extra bit so an all-ones count never wraps below the period.
  function automatic logic period_reached(input logic [DB_CNT_W-1:0] c,
                                          input logic [DB_CNT_W-1:0] p);
    return ({1'b0, c} + (DB_CNT_W+1)'(1)) >= {1'b0, p};
  endfunction

  logic                wr_en;
  logic [WIDTH-1:0]    wr_bits;
  logic [DB_CNT_W-1:0] wr_period;
  logic                unused_wdata;

  logic [WIDTH-1:0]    sync_p0;
  logic [WIDTH-1:0]    sync_p1;
  logic [WIDTH-1:0]    db;
  logic [WIDTH-1:0]    db_next;
  logic [DB_CNT_W-1:0] cnt      [WIDTH];
  logic [DB_CNT_W-1:0] cnt_next [WIDTH];

  logic [WIDTH-1:0]    irq_mask;
  logic [WIDTH-1:0]    edge_cap;
  logic [WIDTH-1:0]    edge_cap_next;
  logic [WIDTH-1:0]    edge_clr;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    fall;
  logic [WIDTH-1:0]    rise_en;
  logic [WIDTH-1:0]    fall_en;
  logic [DB_CNT_W-1:0] db_period;

  logic [31:0]         event_rd;
  logic [31:0]         rd_mux;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wr_bits      = bus.writedata[WIDTH-1:0];
  assign wr_period    = bus.writedata[DB_CNT_W-1:0];
  assign unused_wdata = ^bus.writedata;

  // Stage p0/p1: two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: db follows sync_p1 once a mismatch has persisted db_period cycles.
  always_comb begin
    db_next = db;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync_p1[i] != db[i]) begin
        if (period_reached(cnt[i], db_period)) begin
          db_next[i] = sync_p1[i];
        end else begin
          cnt_next[i] = cnt_sat_inc(cnt[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db <= db_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // Edge capture: a new edge in the same cycle as a write-1-to-clear keeps the bit set.
  assign rise          = db_next & ~db & rise_en;
  assign fall          = ~db_next & db & fall_en;
  assign edge_clr      = (wr_en && bus.address == ADDR_EDGE) ? wr_bits : '0;
  assign edge_cap_next = (edge_cap & ~edge_clr) | rise | fall;
  assign irq           = |(edge_cap & irq_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask  <= '0;
      edge_cap  <= '0;
      rise_en   <= '1;
      fall_en   <= '0;
      db_period <= DB_CNT_W'(DB_DEFAULT);
    end else begin
      edge_cap <= edge_cap_next;
      if (wr_en) begin
        case (bus.address)
          ADDR_MASK:   irq_mask  <= wr_bits;
          ADDR_RISE:   rise_en   <= wr_bits;
          ADDR_FALL:   fall_en   <= wr_bits;
          ADDR_PERIOD: db_period <= wr_period;
          default: ;
        endcase
      end
    end
  end

`ifdef BUTTON_PIO_EVENT_COUNT_EN
  function automatic logic [15:0] event_sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  logic [15:0] event_cnt;
  logic        event_hit;

  // One event per cycle in which any capture bit goes 0 -> 1, however many channels fire.
  assign event_hit = |(edge_cap_next & ~edge_cap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_cnt <= '0;
    end else if (wr_en && bus.address == ADDR_EVENT) begin
      event_cnt <= event_hit ? 16'd1 : 16'd0;
    end else if (event_hit) begin
      event_cnt <= event_sat_inc(event_cnt);
    end
  end

  assign event_rd = 32'(event_cnt);
`else
  assign event_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:   rd_mux = 32'(db);
      ADDR_RAW:    rd_mux = 32'(sync_p1);
      ADDR_MASK:   rd_mux = 32'(irq_mask);
      ADDR_EDGE:   rd_mux = 32'(edge_cap);
      ADDR_RISE:   rd_mux = 32'(rise_en);
      ADDR_FALL:   rd_mux = 32'(fall_en);
      ADDR_PERIOD: rd_mux = 32'(db_period);
      ADDR_EVENT:  rd_mux = event_rd;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_mux;
    end
  end

endmodule
